// File: rtl/pong_pkg.sv
// Shared Pong sound definitions: burst states, event priorities and default burst lengths.
// Game logic may reference the *_DEF constants to stay in step with the sequencer.
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PAD   = 2'd1,
    WALL  = 2'd2,
    SCORE = 2'd3
  } snd_state_t;

  localparam logic [1:0] PRIO_IDLE  = 2'd0;
  localparam logic [1:0] PRIO_WALL  = 2'd1;
  localparam logic [1:0] PRIO_PAD   = 2'd2;
  localparam logic [1:0] PRIO_SCORE = 2'd3;

  localparam int unsigned PAD_TICKS_DEF   = 8;
  localparam int unsigned WALL_TICKS_DEF  = 4;
  localparam int unsigned SCORE_TICKS_DEF = 48;
  localparam int unsigned SCORE_STEP_DEF  = 8;

  function automatic logic [1:0] snd_prio(input snd_state_t s);
    case (s)
      PAD:     snd_prio = PRIO_PAD;
      WALL:    snd_prio = PRIO_WALL;
      SCORE:   snd_prio = PRIO_SCORE;
      default: snd_prio = PRIO_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/tick_timer.sv
// Loadable down-counter; expire_o is combinational, high when a tick arrives with count == 1.
// Load has priority over the tick; no backpressure, a tick is always consumed.
module tick_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         tick_i,
  output logic         expire_o
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (tick_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = tick_i && (cnt_q == ONE);

endmodule

// File: rtl/pong_sound.sv
// Prioritised game-event tone sequencer; buzzer/busy are registered, 1 clk after event or tone.
// No backpressure: lower-priority events during a burst are dropped, never queued.
module pong_sound
  import pong_pkg::*;
#(
  parameter int unsigned PAD_TICKS   = PAD_TICKS_DEF,
  parameter int unsigned WALL_TICKS  = WALL_TICKS_DEF,
  parameter int unsigned SCORE_TICKS = SCORE_TICKS_DEF,
  parameter int unsigned SCORE_STEP  = SCORE_STEP_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic game_en,
  input  logic pad_buzz_en,
  input  logic wall_buzz_en,
  input  logic pad_hit,
  input  logic wall_hit,
  input  logic score_evt,
  input  logic mute,
  output logic buzzer,
  output logic busy
);

  snd_state_t state_q, state_d, ev_state;
  logic       alt_q, alt_d;
  logic       accept, score_acc;
  logic [5:0] dur_val;
  logic       dur_tick, dur_exp;
  logic       step_tick, step_load, step_exp;
  logic       tone;
  logic [1:0] cur_prio;

  assign cur_prio = snd_prio(state_q);

  // Highest-priority pulse wins; it must also be at least as important as the running burst.
  always_comb begin
    accept    = 1'b0;
    score_acc = 1'b0;
    ev_state  = IDLE;
    dur_val   = '0;
    if (score_evt) begin
      accept    = 1'b1;
      score_acc = 1'b1;
      ev_state  = SCORE;
      dur_val   = 6'(SCORE_TICKS);
    end else if (pad_hit && (cur_prio <= PRIO_PAD)) begin
      accept   = 1'b1;
      ev_state = PAD;
      dur_val  = 6'(PAD_TICKS);
    end else if (wall_hit && (cur_prio <= PRIO_WALL)) begin
      accept   = 1'b1;
      ev_state = WALL;
      dur_val  = 6'(WALL_TICKS);
    end
  end

  assign dur_tick  = game_en && (state_q != IDLE);
  assign step_tick = game_en && (state_q == SCORE);
  assign step_load = score_acc || step_exp;

  tick_timer #(.W(6)) u_dur (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (accept),
    .load_val_i(dur_val),
    .tick_i    (dur_tick),
    .expire_o  (dur_exp)
  );

  tick_timer #(.W(4)) u_step (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (step_load),
    .load_val_i(4'(SCORE_STEP)),
    .tick_i    (step_tick),
    .expire_o  (step_exp)
  );

  // Tone is chosen from the next state so buzzer and busy change on the same edge.
  always_comb begin
    state_d = state_q;
    alt_d   = alt_q;
    if (accept) begin
      state_d = ev_state;
    end else if (dur_exp) begin
      state_d = IDLE;
    end
    if (score_acc) begin
      alt_d = 1'b0;
    end else if (step_exp) begin
      alt_d = ~alt_q;
    end
    case (state_d)
      PAD:     tone = pad_buzz_en;
      WALL:    tone = wall_buzz_en;
      SCORE:   tone = alt_d ? wall_buzz_en : pad_buzz_en;
      default: tone = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      alt_q   <= 1'b0;
      buzzer  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      alt_q   <= alt_d;
      buzzer  <= tone && !mute;
      busy    <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_pong_sound.sv
// Directed bench for pong_sound: burst lengths, priority, jingle alternation, mute and async reset.
module tb_pong_sound;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic game_en = 1'b0;
  logic pad_buzz_en = 1'b0;
  logic wall_buzz_en = 1'b0;
  logic pad_hit = 1'b0;
  logic wall_hit = 1'b0;
  logic score_evt = 1'b0;
  logic mute = 1'b0;
  logic buzzer;
  logic busy;

  int checks = 0;
  int errs = 0;
  int cyc_n = 0;
  logic last_pad = 1'b0;
  logic last_wall = 1'b0;
  logic last_mute = 1'b0;

  always #5 clk = ~clk;

  pong_sound dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .game_en     (game_en),
    .pad_buzz_en (pad_buzz_en),
    .wall_buzz_en(wall_buzz_en),
    .pad_hit     (pad_hit),
    .wall_hit    (wall_hit),
    .score_evt   (score_evt),
    .mute        (mute),
    .buzzer      (buzzer),
    .busy        (busy)
  );

  task automatic chk(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, remember what the DUT samples, step past the edge.
  task automatic cyc(input logic ge, input logic ph, input logic wh, input logic se);
    game_en   = ge;
    pad_hit   = ph;
    wall_hit  = wh;
    score_evt = se;
    last_pad  = pad_buzz_en;
    last_wall = wall_buzz_en;
    last_mute = mute;
    @(posedge clk);
    #1;
    game_en   = 1'b0;
    pad_hit   = 1'b0;
    wall_hit  = 1'b0;
    score_evt = 1'b0;
    cyc_n++;
    pad_buzz_en  = ((cyc_n / 3) % 2) == 1;
    wall_buzz_en = ((cyc_n / 2) % 2) == 1;
  endtask

  // kind: 0 idle, 1 paddle, 2 wall, 3 score jingle (alternates every 8 ticks, pad first)
  function automatic logic tone(input int kind, input int done);
    case (kind)
      1:       tone = last_pad;
      2:       tone = last_wall;
      3:       tone = (((done / 8) % 2) == 1) ? last_wall : last_pad;
      default: tone = 1'b0;
    endcase
  endfunction

  task automatic chk_out(input string tag, input int kind, input int done, input int total);
    logic be;
    be = (kind != 0) && (done < total);
    chk({tag, "_busy"}, busy, be);
    chk({tag, "_buzzer"}, buzzer, be ? (tone(kind, done) && !last_mute) : 1'b0);
  endtask

  task automatic ticks(input int kind, input int done0, input int n, input int gap,
                       input int total, input string tag);
    int done;
    done = done0;
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gap; g++) begin
        logic ge;
        ge = (g == gap - 1);
        cyc(ge, 1'b0, 1'b0, 1'b0);
        if (ge) done++;
        chk_out(tag, kind, done, total);
      end
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_buzzer", buzzer, 1'b0);
    rst_n = 1'b1;
    ticks(0, 0, 2, 3, 0, "idle0");

    // paddle burst, ticks 100 clk apart
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk_out("t1_hit", 1, 0, 8);
    ticks(1, 0, 8, 100, 8, "t1");

    // wall retrigger with 2 ticks left, then wall ignored during paddle
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk_out("t2_hit", 2, 0, 4);
    ticks(2, 0, 2, 5, 4, "t2a");
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk_out("t2_rehit", 2, 0, 4);
    ticks(2, 0, 4, 5, 4, "t2b");
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk_out("t2_pad", 1, 0, 8);
    ticks(1, 0, 3, 5, 8, "t2c");
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk_out("t2_drop", 1, 3, 8);
    ticks(1, 3, 5, 5, 8, "t2d");

    // simultaneous events: score wins
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    chk_out("t3_hit", 3, 0, 48);
    ticks(3, 0, 48, 4, 48, "t3");
    ticks(0, 0, 1, 3, 0, "t3_idle");

    // score coincident with a tick, mid-paddle: tick not counted
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(1, 0, 2, 4, 8, "t4_pad");
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    chk_out("t4_hit", 3, 0, 48);
    ticks(3, 0, 48, 3, 48, "t4");

    // mute during paddle burst
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk_out("t5_hit", 1, 0, 8);
    ticks(1, 0, 2, 5, 8, "t5a");
    mute = 1'b1;
    ticks(1, 2, 3, 5, 8, "t5_mute");
    mute = 1'b0;
    ticks(1, 5, 3, 5, 8, "t5b");

    // asynchronous reset mid-jingle
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    ticks(3, 0, 10, 4, 48, "t6a");
    #3 rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_buzzer", buzzer, 1'b0);
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    ticks(0, 0, 10, 4, 0, "t6b");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/pong_sound.md
# pong_sound

Audio sequencer for the Pong datapath, directly downstream of the enable generator. It consumes the game tick (`game_en`) and the two free-running tone square waves (`pad_buzz_en`, `wall_buzz_en`). It turns single-cycle game events (paddle hit, wall bounce, point scored) into timed, prioritised tone bursts on a single registered buzzer pin. When the game is paused the tick stops, so burst timing freezes with it.

## Interface

Parameters:
- `PAD_TICKS`, 8: paddle-hit burst length, in `game_en` pulses (1..63)
- `WALL_TICKS`, 4: wall-bounce burst length, in `game_en` pulses (1..63)
- `SCORE_TICKS`, 48: score jingle length, in `game_en` pulses (1..63)
- `SCORE_STEP`, 8: `game_en` pulses per jingle note (1..15)

Ports:
- `clk`  in  1: system pixel clock, 25.175 MHz
- `rst_n`  in  1: asynchronous active-low reset
- `game_en`  in  1: one-cycle game tick from the enable generator
- `pad_buzz_en`  in  1: low-pitch square wave (paddle tone)
- `wall_buzz_en`  in  1: high-pitch square wave (wall tone)
- `pad_hit`  in  1: one-cycle pulse, ball struck a paddle
- `wall_hit`  in  1: one-cycle pulse, ball struck top or bottom wall
- `score_evt`  in  1: one-cycle pulse, point scored
- `mute`  in  1: level; forces buzzer low, sequencing continues
- `buzzer`  out  1: registered speaker drive
- `busy`  out  1: high while any burst is active

## Operation

- FSM states: IDLE, PAD, WALL, SCORE. Priority is SCORE > PAD > WALL.
- Event acceptance (same cycle as the pulse):
  - An event whose priority is greater than or equal to the current state's enters (or re-enters) its state.
  - The duration counter loads `*_TICKS`. In SCORE, `alt` clears and the step counter loads `SCORE_STEP`.
  - A lower-priority event is dropped. There is no queueing.
- Simultaneous events in one cycle: the highest priority wins. The others are dropped.
- Duration counter: 6-bit, decrements on each `game_en` in a non-IDLE state.
  - On a `game_en` with counter == 1, the FSM goes to IDLE.
  - The burst therefore lasts exactly `*_TICKS` `game_en` pulses.
- Event and `game_en` in the same cycle: the event load wins and that `game_en` is not counted.
- SCORE jingle: a 4-bit step counter decrements on `game_en`. On reaching 1 it reloads `SCORE_STEP` and toggles `alt`.
  - `alt`=0 plays the paddle tone; `alt`=1 plays the wall tone.
- Tone select by state:
  - IDLE: 0
  - PAD: `pad_buzz_en`
  - WALL: `wall_buzz_en`
  - SCORE: as selected by `alt`
- `buzzer` <= selected tone AND NOT `mute`.
- `busy` <= (next state != IDLE).
- Reset: the FSM goes to IDLE and all counters and `alt` go to 0. `buzzer`=0, `busy`=0.
  - Reset mid-burst aborts the burst immediately.
  - No event is remembered across reset.

## Timing

- Event to `busy` high: 1 clk, on the edge after the pulse.
- Event to `buzzer` following the tone: 1 clk. `buzzer` is a registered copy of the selected tone, so it lags the input square waves by 1 clk.
- End of burst: on the edge after the final counted `game_en`, `busy` falls and `buzzer` is 0 on the same edge.
- `game_en` held low (paused): state, counters and `alt` hold. `buzzer` keeps tracking the selected square wave, which is itself frozen while paused.
- `mute` acts with 1 clk latency. It never changes state or counters.

## Structure

- Shared package `pong_pkg`:
  - state enum `snd_state_t` (IDLE, PAD, WALL, SCORE)
  - 2-bit priority constants
  - default tick constants, so that game logic can reference burst lengths
- Sub-module `tick_timer`: loadable down-counter.
  - Inputs: load, load value, tick enable.
  - Output: `expire`, asserted when a tick arrives with count == 1.
  - Two instances: burst duration (6 bit) and score step (4 bit).
- The FSM, tone mux and output registers live in `pong_sound`.

## Test plan

1. Reset, then `pad_hit` pulse, then 8 `game_en` pulses spaced 100 clk apart:
   - `busy` rises 1 clk after the hit and falls 1 clk after the 8th `game_en`.
   - `buzzer` equals `pad_buzz_en` delayed by 1 clk throughout.
2. `wall_hit` while WALL is active, with 2 ticks left:
   - The burst restarts and lasts 4 more ticks.
   - Then a `wall_hit` during PAD is ignored and PAD ends on schedule.
3. `pad_hit`, `wall_hit` and `score_evt` asserted in the same cycle:
   - State is SCORE and lasts 48 ticks.
   - The buzzer source alternates pad/wall every 8 ticks, 6 notes in total, starting with pad.
4. `score_evt` coincident with `game_en`:
   - The counter loads 48 and the tick is not counted.
   - `busy` falls after the 48th subsequent tick.
5. `mute`=1 during PAD:
   - `buzzer` stays 0 from 1 clk after `mute` rises.
   - `busy` timing is unchanged.
   - Dropping `mute` mid-burst resumes the tone 1 clk later.
6. `rst_n` low mid-SCORE, asynchronously between clock edges:
   - `buzzer` and `busy` go to 0 immediately.
   - After release, with no events, both stay 0 over 10 `game_en` pulses.
